// File: rtl/inst_queue.sv
// ---------------------------------------------------------------------------
// inst_queue
//
// Instruction buffer between fetch and decode. Holds up to DEPTH fetched
// instructions together with their PCs. Each instruction's immediate and
// format class are pre-decoded when it enters the queue. The oldest entry is
// presented to decode through a valid/ready handshake. A one-cycle
// synchronous flush discards every stored entry for branch/jump redirects.
//
// Parameters
//   XLEN   data/PC width (32 or 64)
//   DEPTH  entry count (power of two, >= 2)
//   CNT_W  occupancy counter width, derived from DEPTH
//
// Ports
//   clk       clock; all state updates on the rising edge
//   rst       synchronous active-high reset
//   flush     discard all entries and any same-cycle push
//   if_valid  fetch offers an instruction
//   if_ready  queue accepts a push this cycle
//   if_pc     PC of the offered instruction
//   if_inst   offered instruction word
//   id_valid  head entry is valid
//   id_ready  decode consumes the head this cycle
//   id_pc     head PC (0 when empty)
//   id_inst   head instruction (0 when empty)
//   id_imm    head sign-extended immediate (0 when empty)
//   id_fmt    head format: 0 ILLEGAL,1 U,2 J,3 I,4 B,5 S,6 R (0 when empty)
//   count     current occupancy
// ---------------------------------------------------------------------------
module inst_queue #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             if_valid,
    output logic             if_ready,
    input  logic [XLEN-1:0]  if_pc,
    input  logic [31:0]      if_inst,
    output logic             id_valid,
    input  logic             id_ready,
    output logic [XLEN-1:0]  id_pc,
    output logic [31:0]      id_inst,
    output logic [XLEN-1:0]  id_imm,
    output logic [2:0]       id_fmt,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [2:0] FMT_ILLEGAL = 3'd0;
    localparam logic [2:0] FMT_U       = 3'd1;
    localparam logic [2:0] FMT_J       = 3'd2;
    localparam logic [2:0] FMT_I       = 3'd3;
    localparam logic [2:0] FMT_B       = 3'd4;
    localparam logic [2:0] FMT_S       = 3'd5;
    localparam logic [2:0] FMT_R       = 3'd6;

    // Format class from the major opcode.
    function automatic logic [2:0] dec_fmt(input logic [31:0] inst);
        logic [2:0] fmt;
        case (inst[6:0])
            OPC_LUI, OPC_AUIPC:           fmt = FMT_U;
            OPC_JAL:                      fmt = FMT_J;
            OPC_JALR, OPC_LOAD, OPC_OPIMM: fmt = FMT_I;
            OPC_BRANCH:                   fmt = FMT_B;
            OPC_STORE:                    fmt = FMT_S;
            OPC_OP:                       fmt = FMT_R;
            default:                      fmt = FMT_ILLEGAL;
        endcase
        return fmt;
    endfunction

    // Sign-extended immediate. The top replication field carries the sign bit
    // (inst[31]) so every format extends correctly for either XLEN.
    function automatic logic signed [XLEN-1:0] dec_imm(input logic [31:0] inst);
        logic signed [XLEN-1:0] imm;
        case (inst[6:0])
            OPC_LUI, OPC_AUIPC:
                imm = {{(XLEN-31){inst[31]}}, inst[30:12], 12'b0};
            OPC_JAL:
                imm = {{(XLEN-20){inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
            OPC_JALR, OPC_LOAD:
                imm = {{(XLEN-11){inst[31]}}, inst[30:20]};
            OPC_OPIMM: begin
                // SLLI/SRLI/SRAI carry a zero-extended shift amount; the
                // funct7/funct6 bits above it must not leak into the immediate.
                if (inst[13:12] == 2'b01)
                    imm = (XLEN == 64) ? XLEN'(inst[25:20]) : XLEN'(inst[24:20]);
                else
                    imm = {{(XLEN-11){inst[31]}}, inst[30:20]};
            end
            OPC_BRANCH:
                imm = {{(XLEN-12){inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
            OPC_STORE:
                imm = {{(XLEN-11){inst[31]}}, inst[30:25], inst[11:7]};
            default:
                imm = '0;
        endcase
        return imm;
    endfunction

    logic [XLEN-1:0]  pc_mem   [DEPTH];
    logic [31:0]      inst_mem [DEPTH];
    logic [XLEN-1:0]  imm_mem  [DEPTH];
    logic [2:0]       fmt_mem  [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic             push;
    logic             pop;

    assign if_ready = !rst && (cnt < CNT_W'(DEPTH));
    assign id_valid = (cnt != '0);
    assign push     = if_valid && if_ready && !flush;
    assign pop      = id_valid && id_ready && !flush;
    assign count    = cnt;

    // Entry capture: storage is never reset; emptiness is tracked by cnt.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]   <= if_pc;
            inst_mem[wr_ptr] <= if_inst;
            imm_mem[wr_ptr]  <= dec_imm(if_inst);
            fmt_mem[wr_ptr]  <= dec_fmt(if_inst);
        end
    end

    // Control state: pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Head read: stale storage is masked so an empty queue reads all zeros.
    assign id_pc   = id_valid ? pc_mem[rd_ptr]   : '0;
    assign id_inst = id_valid ? inst_mem[rd_ptr] : '0;
    assign id_imm  = id_valid ? imm_mem[rd_ptr]  : '0;
    assign id_fmt  = id_valid ? fmt_mem[rd_ptr]  : '0;

endmodule
